pre_if_pcgen: RTL

PRE_IF_PCGEN -- requirements
Module: pre_if_pcgen

---
 rtl/pre_if_pcgen.sv | 114 +++++++++++
 1 files changed

// File: rtl/pre_if_pcgen.sv
// Pre-IF fetch PC generator: selects the next fetch address (flush / hold / BTB / sequential)
// and registers it as the PC presented to IF.
// Latency: nextpc_o is combinational; pc_o follows nextpc_o one cycle later.
// Backpressure: if_allowin_i=0 holds pc_o, which keeps the BTB read aligned. Flushes override the hold.
//
// Ports:
//   clk            - sole clock, rising edge
//   rst_n          - asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   if_allowin_i   - IF accepts pc_o this cycle
//   btb_hit_i      - BTB hit for the current pc_o (looked up via last cycle's nextpc_o)
//   btb_target_i   - BTB predicted target, qualified by btb_hit_i
//   excp_flush_i   - exception/ertn redirect request (highest priority)
//   excp_pc_i      - exception/ertn redirect target
//   br_flush_i     - branch-mispredict redirect
//   br_pc_i        - corrected branch target
//   nextpc_o       - combinational next fetch PC, also the BTB read address
//   pc_o           - registered fetch PC
//   pc_valid_o     - pc_o is a valid fetch request
//   pred_taken_o   - BTB predicted a taken redirect after pc_o
//   pred_target_o  - predicted successor of pc_o (BTB target when hit, else sequential)

module pre_if_pcgen #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_allowin_i,
    input  logic        btb_hit_i,
    input  logic [31:0] btb_target_i,
    input  logic        excp_flush_i,
    input  logic [31:0] excp_pc_i,
    input  logic        br_flush_i,
    input  logic [31:0] br_pc_i,
    output logic [31:0] nextpc_o,
    output logic [31:0] pc_o,
    output logic        pc_valid_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic        r_pc_valid;
    logic [31:0] w_nextpc;
    logic        w_pc_valid_nxt;
    logic [31:0] w_seq_pc;
    logic        w_pred_hit;

    // Dual-issue fetch block: the sequential successor is the next 8-byte aligned
    // block, regardless of the low bits of an unaligned redirect target.
    assign w_seq_pc = {r_pc[31:3], 3'b000} + 32'd8;

    // Prediction outputs are only meaningful for a valid pc_o; in BOOT they
    // fall back to not-taken / sequential.
    assign w_pred_hit = r_pc_valid & btb_hit_i;

    always_comb begin
        w_state_nxt    = r_state;
        w_nextpc       = RESET_PC;
        w_pc_valid_nxt = r_pc_valid;
        unique case (r_state)
            ST_BOOT: begin
                // Flushes and BTB are ignored until the first real fetch.
                w_state_nxt    = ST_RUN;
                w_nextpc       = RESET_PC;
                w_pc_valid_nxt = 1'b1;
            end
            ST_RUN: begin
                w_state_nxt    = ST_RUN;
                w_pc_valid_nxt = 1'b1;
                // Flushes win over the stall: the wrong-path pc_o is simply
                // overwritten. A br flush colliding with an exception is dropped.
                if (excp_flush_i) begin
                    w_nextpc = excp_pc_i;
                end else if (br_flush_i) begin
                    w_nextpc = br_pc_i;
                end else if (!if_allowin_i) begin
                    // Re-present the same address so the BTB result stays
                    // aligned with pc_o across the stall.
                    w_nextpc = r_pc;
                end else if (btb_hit_i) begin
                    w_nextpc = btb_target_i;
                end else begin
                    w_nextpc = w_seq_pc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= 32'h0;
            r_pc_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_nextpc;
            r_pc_valid <= w_pc_valid_nxt;
        end
    end

    assign nextpc_o      = w_nextpc;
    assign pc_o          = r_pc;
    assign pc_valid_o    = r_pc_valid;
    assign pred_taken_o  = w_pred_hit;
    assign pred_target_o = w_pred_hit ? btb_target_i : w_seq_pc;

endmodule
